// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and the control unit.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF  = 12;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned MEM_LAT_DEF = 2;

   // Bit positions inside the control unit's MEM_signals field
   localparam int unsigned MEM_RD       = 3;
   localparam int unsigned MEM_WR       = 2;
   localparam int unsigned MEM_ADDR_SEL = 1;
   localparam int unsigned MEM_DATA_SEL = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_FETCH = 2'd2
   } arb_state_e;

   // Width needed to hold a count of 0..lat (at least one bit)
   function automatic int unsigned lat_cnt_w(input int unsigned lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-stage and memory-side signals around the arbiter.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_read;
   logic              dm_write;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_done;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;
   logic              proto_err;

   // Arbiter side
   modport slave (
      input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
      output if_rvalid, if_rdata, dm_done, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem, proto_err
   );

   // Pipeline / memory side
   modport master (
      output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
      input  if_rvalid, if_rdata, dm_done, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem, proto_err
   );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory latency.
module mem_lat_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int unsigned CNT_W = lat_cnt_w(MEM_LAT);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load takes priority; decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   arb_state_e        state_q, state_d;
   logic              op_wr_q, op_wr_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              dm_done_q, dm_done_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              proto_err_q, proto_err_d;

   logic              mem_en_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;

   logic              data_req;
   logic              data_elig;
   logic              fetch_elig;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;

   // A requester that is completing this cycle still holds its request; mask it
   assign data_req   = bus.dm_read | bus.dm_write;
   assign data_elig  = data_req & ~dm_done_q;
   assign fetch_elig = bus.if_req & ~if_rvalid_q;

   mem_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   // Grant, latency sequencing and result capture
   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      if_rvalid_d = 1'b0;
      dm_done_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      proto_err_d = proto_err_q | (bus.dm_read & bus.dm_write);
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (data_elig) begin
               mem_en_c    = 1'b1;
               mem_we_c    = bus.dm_write;
               mem_addr_c  = bus.dm_addr;
               mem_wdata_c = bus.dm_wdata;
               op_wr_d     = bus.dm_write;
               cnt_load    = 1'b1;
               state_d     = ST_DATA;
            end else if (fetch_elig) begin
               mem_en_c    = 1'b1;
               mem_addr_c  = bus.if_addr;
               cnt_load    = 1'b1;
               state_d     = ST_FETCH;
            end
         end
         ST_DATA: begin
            if (cnt_zero) begin
               dm_done_d = 1'b1;
               if (!op_wr_q) begin
                  dm_rdata_d = bus.mem_rdata;
               end
               state_d = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_FETCH: begin
            if (cnt_zero) begin
               if_rvalid_d = 1'b1;
               if_rdata_d  = bus.mem_rdata;
               state_d     = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // No memory access may be issued while reset is asserted
      if (rst) begin
         mem_en_c    = 1'b0;
         mem_we_c    = 1'b0;
         mem_addr_c  = '0;
         mem_wdata_c = '0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_wr_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_done_q   <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         if_rvalid_q <= if_rvalid_d;
         dm_done_q   <= dm_done_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign bus.mem_en    = mem_en_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wdata = mem_wdata_c;

   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.proto_err = proto_err_q;

   assign bus.stall_mem = data_req & ~dm_done_q;
   assign bus.stall_if  = bus.if_req & ~if_rvalid_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the processor's single-port memory between instruction fetch (read-only) and the MEM stage (LDD reads, STD writes). MEM-stage read/write requests are driven directly from the control unit's MEM_signals bits. The block sequences each access over a fixed memory latency, returns read data and completion pulses, and generates the IF and MEM stall signals for the pipeline.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 16, memory data width
MEM_LAT, 2, cycles from issue (mem_en) to valid mem_rdata; legal range >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_rvalid  out  1  one-cycle pulse: if_rdata valid, fetch complete
if_rdata  out  DATA_W  fetched word (registered)
dm_read  in  1  MEM-stage read (MEM_signals[3])
dm_write  in  1  MEM-stage write (MEM_signals[2])
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_done  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  loaded word (registered)
mem_en  out  1  one-cycle access strobe to memory
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  hold PC/IF stage
stall_mem  out  1  hold pipeline at MEM stage and upstream
proto_err  out  1  sticky: dm_read and dm_write both high

Behaviour:
- FSM states: IDLE, DATA, FETCH. Reset → IDLE.
- IDLE grant (combinational, same cycle T):
  - Data wins if (dm_read|dm_write) is high. Drive mem_en=1, mem_we=dm_write, mem_addr=dm_addr, mem_wdata=dm_wdata. Go to DATA.
  - Otherwise fetch if if_req is high. Drive mem_en=1, mem_we=0, mem_addr=if_addr. Go to FETCH.
  - Otherwise mem_en=0.
- Memory captures addr/we/wdata on the edge ending cycle T. The arbiter does not hold them afterwards.
- Latency counter loads MEM_LAT-1 at grant and decrements in DATA/FETCH. At count 0 (cycle T+MEM_LAT), mem_rdata is sampled into dm_rdata or if_rdata and the FSM returns to IDLE.
- dm_done / if_rvalid pulse high for exactly cycle T+MEM_LAT+1. Total latency is MEM_LAT+1 from grant. Writes also signal dm_done; dm_rdata is unchanged on writes.
- Done cycle: the FSM is IDLE. The completing requester's request is still asserted by the stalled stage and must not be re-granted:
  - data request ignored in the dm_done cycle;
  - if_req ignored in the if_rvalid cycle;
  - the other requester may be granted in that cycle.
  This gives back-to-back issue and prevents fetch starvation.
- stall_mem = (dm_read|dm_write) & ~dm_done.
- stall_if = if_req & ~if_rvalid. Combinational; high in the grant cycle.
- Request dropped mid-access: the access still completes and the done pulse still fires.
- dm_read & dm_write both high: treated as a write, and proto_err is set until reset.
- Outside grant cycles: mem_en=0, mem_we=0. mem_addr/mem_wdata are don't-care but driven to 0.
- Reset (any state, including mid-access):
  - next cycle is IDLE, counter 0;
  - if_rvalid, dm_done, if_rdata, dm_rdata, proto_err all 0;
  - mem_en=0 during the reset cycle;
  - in-flight result discarded, no done pulse.
- Counter width = clog2(MEM_LAT+1); no wrap.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/DATA/FETCH);
  - MEM_signals bit indices (MEM_RD=3, MEM_WR=2, MEM_ADDR_SEL=1, MEM_DATA_SEL=0), shared with the control unit.
- One sub-module: mem_lat_counter, a loadable down-counter with a zero flag, parameterized by MEM_LAT.

Test Plan (MEM_LAT=2):
1. Fetch only: if_req=1, if_addr=0x010 at T.
   - T: mem_en=1, mem_we=0, mem_addr=0x010.
   - mem_rdata=0xBEEF at T+2.
   - T+3: if_rvalid=1, if_rdata=0xBEEF.
   - stall_if=1 for T..T+2, 0 at T+3.
2. Collision: if_req and dm_read (dm_addr=0x040) both high at T.
   - Data granted at T; dm_done at T+3.
   - Fetch granted at T+3; if_rvalid at T+6.
   - stall_mem low at T+3.
3. Store: dm_write=1, dm_addr=0x020, dm_wdata=0x1234 at T.
   - T: mem_en=1, mem_we=1, mem_wdata=0x1234.
   - dm_done at T+3; no second mem_en at T+3 with the request still high.
4. LDD then STD back-to-back (new request presented at T+4).
   - Second grant at T+4; dm_done at T+3 and T+7.
   - dm_rdata keeps the load value after the store.
5. Reset at T+1 during a load.
   - T+2: IDLE, all outputs 0.
   - No dm_done at T+3.
   - A new if_req is granted immediately.
6. dm_read=dm_write=1 at T.
   - Write issued (mem_we=1); proto_err=1 from T+1 until rst.
